sram_save: RTL

- Save-path counterpart of the download/upload chain. Download moves data DDR3→SDRAM; this block moves it back.
- On request, copies a cartridge's battery-backed SRAM image from SDRAM into a per-slot DDR3 buffer, byte by byte, so the HPS can write it to the SD card.
- Sits beside the download block and shares its DDR3/SDRAM request-mux convention: it holds request high while it owns the bus.

---
 rtl/sram_save_pkg.sv | 18 +
 rtl/sram_save.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/sram_save_pkg.sv
// Shared types and address-map constants for the SRAM save path (SDRAM -> DDR3).
// The HPS side reads save buffers at SAVE_DDR3_BASE + slot * SAVE_SLOT_STRIDE.
package sram_save_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StGrant,
        StRd,
        StWr,
        StTail,
        StDone
    } save_state_t;

    localparam logic [27:0] SAVE_DDR3_BASE   = 28'h1F00000;
    localparam logic [27:0] SAVE_SLOT_STRIDE = 28'h0010000;
    localparam int unsigned SAVE_SIZE_W      = 17;

endpackage

// File: rtl/sram_save.sv
// Copies a cartridge SRAM image from SDRAM into a per-slot DDR3 buffer, one byte at a time.
// Define SRAM_SAVE_CHECKSUM_EN to append the inverted 8-bit byte sum after the image.
module sram_save
    import sram_save_pkg::*;
#(
    parameter logic [27:0] DDR3_BASE   = SAVE_DDR3_BASE,
    parameter logic [27:0] SLOT_STRIDE = SAVE_SLOT_STRIDE,
    parameter int unsigned SIZE_W      = SAVE_SIZE_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              save_req,
    input  logic              save_slot,
    input  logic [24:0]       sram_base,
    input  logic [SIZE_W-1:0] sram_size,
    output logic              sdram_request,
    output logic [24:0]       sdram_addr,
    output logic              sdram_rd,
    input  logic [7:0]        sdram_dout,
    input  logic              sdram_ready,
    output logic              ddr3_request,
    output logic [27:0]       ddr3_addr,
    output logic [7:0]        ddr3_din,
    output logic              ddr3_wr,
    input  logic              ddr3_ready,
    output logic              busy,
    output logic              done
);

    save_state_t       state_q, state_d;
    logic              slot_q, slot_d;
    logic [24:0]       base_q, base_d;
    logic [SIZE_W-1:0] size_q, size_d;
    logic [SIZE_W-1:0] idx_q, idx_d;
    logic [7:0]        data_q, data_d;
    logic [SIZE_W-1:0] idx_inc;
    logic [27:0]       ddr3_target;

`ifdef SRAM_SAVE_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
`endif

    assign idx_inc     = idx_q + SIZE_W'(1);
    // In TAIL idx_q equals size_q, so the same target lands on buffer + size.
    assign ddr3_target = DDR3_BASE + (slot_q ? SLOT_STRIDE : 28'd0) + 28'(idx_q);

    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        base_d        = base_q;
        size_d        = size_q;
        idx_d         = idx_q;
        data_d        = data_q;
`ifdef SRAM_SAVE_CHECKSUM_EN
        sum_d         = sum_q;
`endif
        sdram_request = 1'b0;
        sdram_addr    = 25'd0;
        sdram_rd      = 1'b0;
        ddr3_request  = 1'b0;
        ddr3_addr     = 28'd0;
        ddr3_din      = 8'd0;
        ddr3_wr       = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (save_req) begin
                    slot_d  = save_slot;
                    base_d  = sram_base;
                    size_d  = sram_size;
                    idx_d   = '0;
`ifdef SRAM_SAVE_CHECKSUM_EN
                    sum_d   = 8'd0;
`endif
                    state_d = (sram_size == '0) ? StDone : StGrant;
                end
            end
            StGrant: begin
                sdram_request = 1'b1;
                ddr3_request  = 1'b1;
                busy          = 1'b1;
                state_d       = StRd;
            end
            StRd: begin
                sdram_request = 1'b1;
                ddr3_request  = 1'b1;
                busy          = 1'b1;
                sdram_rd      = 1'b1;
                sdram_addr    = base_q + 25'(idx_q);
                if (sdram_ready) begin
                    data_d  = sdram_dout;
`ifdef SRAM_SAVE_CHECKSUM_EN
                    sum_d   = sum_q + sdram_dout;
`endif
                    state_d = StWr;
                end
            end
            StWr: begin
                sdram_request = 1'b1;
                ddr3_request  = 1'b1;
                busy          = 1'b1;
                ddr3_wr       = 1'b1;
                ddr3_addr     = ddr3_target;
                ddr3_din      = data_q;
                if (ddr3_ready) begin
                    idx_d = idx_inc;
                    if (idx_inc == size_q) begin
`ifdef SRAM_SAVE_CHECKSUM_EN
                        state_d = StTail;
`else
                        state_d = StDone;
`endif
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StTail: begin
`ifdef SRAM_SAVE_CHECKSUM_EN
                sdram_request = 1'b1;
                ddr3_request  = 1'b1;
                busy          = 1'b1;
                ddr3_wr       = 1'b1;
                ddr3_addr     = ddr3_target;
                ddr3_din      = ~sum_q;
                if (ddr3_ready) begin
                    state_d = StDone;
                end
`else
                state_d = StDone;
`endif
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            slot_q  <= 1'b0;
            base_q  <= 25'd0;
            size_q  <= '0;
            idx_q   <= '0;
            data_q  <= 8'd0;
`ifdef SRAM_SAVE_CHECKSUM_EN
            sum_q   <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            base_q  <= base_d;
            size_q  <= size_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
`ifdef SRAM_SAVE_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

endmodule
